// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic IDLE_LVL    = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversampling counters and 2-of-3 majority voter.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PSWIDTH = 6,
    parameter int BCW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_data_rx,
    input  logic               cnt_en,
    input  logic               bit_clr,
    input  logic [PSWIDTH-1:0] prescale,
    output logic               sd,
    output logic               bit_val,
    output logic               bit_done,
    output logic               bit_end,
    output logic [BCW-1:0]     bit_cnt
);

    logic               sync1;
    logic               samp0;
    logic               samp1;
    logic [PSWIDTH-1:0] edge_cnt;
    logic [PSWIDTH-1:0] half;

    assign half     = prescale >> 1;
    assign bit_end  = cnt_en && (edge_cnt == prescale - PSWIDTH'(1));
    assign bit_done = cnt_en && (edge_cnt == half + PSWIDTH'(1));
    // Third sample is the live synchronized value at the decision point.
    assign bit_val  = (samp0 & samp1) | (samp0 & sd) | (samp1 & sd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= IDLE_LVL;
            sd    <= IDLE_LVL;
        end else begin
            sync1 <= s_data_rx;
            sd    <= sync1;
        end
    end

    // Counters sit at zero while idle so a start edge always begins at edge_cnt = 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_clr ? '0 : bit_cnt + BCW'(1);
        end else begin
            edge_cnt <= edge_cnt + PSWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp0 <= IDLE_LVL;
            samp1 <= IDLE_LVL;
        end else if (cnt_en) begin
            if (edge_cnt == half - PSWIDTH'(1)) begin
                samp0 <= sd;
            end
            if (edge_cnt == half) begin
                samp1 <= sd;
            end
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: frame FSM, shift register, parity/stop checks and
// registered result pulses.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int PSWIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_data_rx,
    input  logic               parity_en_rx,
    input  logic               parity_type_rx,
    input  logic [PSWIDTH-1:0] prescale,
    output logic [DWIDTH-1:0]  p_data_rx,
    output logic               data_valid_rx,
    output logic               parity_err,
    output logic               stop_err,
    output logic               busy_rx
);

    localparam int BCW = $clog2(DWIDTH + 1);

    rx_state_e          state_q;
    rx_state_e          state_d;
    logic [PSWIDTH-1:0] ps_q;
    logic               par_en_q;
    logic               par_type_q;
    logic [DWIDTH-1:0]  shift_q;
    logic               par_err_q;
    logic               par_exp;
    logic               bit_clr;
    logic               sd;
    logic               bit_val;
    logic               bit_done;
    logic               bit_end;
    logic [BCW-1:0]     bit_cnt;

    uart_rx_sampler #(
        .PSWIDTH (PSWIDTH),
        .BCW     (BCW)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .s_data_rx (s_data_rx),
        .cnt_en    (state_q != IDLE),
        .bit_clr   (bit_clr),
        .prescale  (ps_q),
        .sd        (sd),
        .bit_val   (bit_val),
        .bit_done  (bit_done),
        .bit_end   (bit_end),
        .bit_cnt   (bit_cnt)
    );

    assign busy_rx = (state_q != IDLE);
    assign par_exp = (par_type_q == PARITY_EVEN) ? ^shift_q : ~^shift_q;

    // Frame configuration tracks the inputs only while idle, then freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q       <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
        end else if (state_q == IDLE) begin
            ps_q       <= prescale;
            par_en_q   <= parity_en_rx;
            par_type_q <= parity_type_rx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sd) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_done && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == BCW'(DWIDTH - 1))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            // Leave at mid-stop so a following start edge is never missed.
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (state_q == DATA && bit_done) begin
                shift_q <= {bit_val, shift_q[DWIDTH-1:1]};
            end
            if (state_q == START) begin
                par_err_q <= 1'b0;
            end else if (state_q == PARITY && bit_done) begin
                par_err_q <= (bit_val != par_exp);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_rx     <= '0;
            data_valid_rx <= 1'b0;
            parity_err    <= 1'b0;
            stop_err      <= 1'b0;
        end else begin
            data_valid_rx <= 1'b0;
            parity_err    <= 1'b0;
            stop_err      <= 1'b0;
            if (state_q == STOP && bit_done) begin
                if (!bit_val) begin
                    stop_err   <= 1'b1;
                    parity_err <= par_err_q;
                end else if (par_err_q) begin
                    parity_err <= 1'b1;
                end else begin
                    p_data_rx     <= shift_q;
                    data_valid_rx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: stimulus queues expected result pulses,
// a monitor pops and compares them whenever the receiver reports a frame.
module tb_uart_rx_deser;
    import uart_rx_pkg::*;

    localparam int DW  = 8;
    localparam int PSW = 6;

    typedef struct {
        logic          valid;
        logic          perr;
        logic          serr;
        logic [DW-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_data_rx = 1'b1;
    logic           parity_en_rx = 1'b0;
    logic           parity_type_rx = 1'b0;
    logic [PSW-1:0] prescale = 6'd8;
    logic [DW-1:0]  p_data_rx;
    logic           data_valid_rx;
    logic           parity_err;
    logic           stop_err;
    logic           busy_rx;

    exp_t exp_q[$];
    int   vec_count = 0;
    int   miscompares = 0;

    uart_rx_deser #(.DWIDTH(DW), .PSWIDTH(PSW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data_rx      (s_data_rx),
        .parity_en_rx   (parity_en_rx),
        .parity_type_rx (parity_type_rx),
        .prescale       (prescale),
        .p_data_rx      (p_data_rx),
        .data_valid_rx  (data_valid_rx),
        .parity_err     (parity_err),
        .stop_err       (stop_err),
        .busy_rx        (busy_rx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic v, input logic pe, input logic se,
                               input logic [DW-1:0] d);
        exp_t e;
        e.valid = v;
        e.perr  = pe;
        e.serr  = se;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic idleLine(input int n);
        s_data_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One frame, one bit per ps clocks; glitch_bit flips a single clock
    // mid-bit, abort_after stops driving after that many line bits.
    task automatic applyStimulus(input logic [DW-1:0] data, input int ps,
                                 input logic pen, input logic ptype, input logic pbit,
                                 input logic sbit, input int glitch_bit,
                                 input int abort_after);
        logic b[0:DW+2];
        int   n;
        prescale       = PSW'(ps);
        parity_en_rx   = pen;
        parity_type_rx = ptype;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = data[i];
        n = DW + 1;
        if (pen) begin
            b[n] = pbit;
            n++;
        end
        b[n] = sbit;
        n++;
        for (int k = 0; k < n; k++) begin
            if (abort_after > 0 && k == abort_after) return;
            for (int j = 0; j < ps; j++) begin
                s_data_rx = (k == glitch_bit && j == ps/2 + 1) ? ~b[k] : b[k];
                @(negedge clk);
            end
        end
        s_data_rx = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (data_valid_rx || parity_err || stop_err)) begin
                if (exp_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%b perr=%b serr=%b data=0x%0h, expected none",
                             data_valid_rx, parity_err, stop_err, p_data_rx);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("data_valid_rx", data_valid_rx, e.valid);
                    checkOutput("parity_err", parity_err, e.perr);
                    checkOutput("stop_err", stop_err, e.serr);
                    checkOutput("p_data_rx", p_data_rx, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_p_data", p_data_rx, 0);
        checkOutput("reset_valid", data_valid_rx, 0);
        checkOutput("reset_perr", parity_err, 0);
        checkOutput("reset_serr", stop_err, 0);
        checkOutput("reset_busy", busy_rx, 0);
        rst = 1'b1;
        idleLine(5);

        // 0xA5 even parity -> parity bit 0
        expectEvent(1, 0, 0, 8'hA5);
        applyStimulus(8'hA5, 8, 1'b1, PARITY_EVEN, 1'b0, 1'b1, -1, 0);
        idleLine(20);
        checkOutput("hold_A5", p_data_rx, 8'hA5);
        checkOutput("idle_busy", busy_rx, 0);

        // back-to-back at prescale 16
        expectEvent(1, 0, 0, 8'h00);
        expectEvent(1, 0, 0, 8'hFF);
        applyStimulus(8'h00, 16, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 0);
        applyStimulus(8'hFF, 16, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 0);
        idleLine(40);

        // 0x3C has four ones: odd parity bit must be 1, so 0 is a mismatch
        expectEvent(0, 1, 0, 8'hFF);
        applyStimulus(8'h3C, 8, 1'b1, PARITY_ODD, 1'b0, 1'b1, -1, 0);
        idleLine(20);
        checkOutput("hold_after_perr", p_data_rx, 8'hFF);
        expectEvent(1, 0, 0, 8'h3C);
        applyStimulus(8'h3C, 8, 1'b1, PARITY_ODD, 1'b1, 1'b1, -1, 0);
        idleLine(20);

        // stop error at prescale 32, then a clean frame
        expectEvent(0, 0, 1, 8'h3C);
        applyStimulus(8'h5A, 32, 1'b0, PARITY_EVEN, 1'b0, 1'b0, -1, 0);
        idleLine(100);
        checkOutput("hold_after_serr", p_data_rx, 8'h3C);
        expectEvent(1, 0, 0, 8'h5A);
        applyStimulus(8'h5A, 32, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 0);
        idleLine(40);

        // 0x01 even wants parity 1; sending 0 with a bad stop reports both
        expectEvent(0, 1, 1, 8'h5A);
        applyStimulus(8'h01, 8, 1'b1, PARITY_EVEN, 1'b0, 1'b0, -1, 0);
        idleLine(40);

        // start glitch: line low for two clocks
        prescale = 6'd16;
        parity_en_rx = 1'b0;
        s_data_rx = 1'b0;
        repeat (2) @(negedge clk);
        s_data_rx = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("glitch_busy_mid", busy_rx, 1);
        idleLine(30);
        checkOutput("glitch_busy_after", busy_rx, 0);

        // single-sample glitch inside data bit 3 of 0x96
        expectEvent(1, 0, 0, 8'h96);
        applyStimulus(8'h96, 16, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 4, 0);
        idleLine(40);

        // reset in the middle of the data bits of 0x77
        applyStimulus(8'h77, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 4);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_p_data", p_data_rx, 0);
        checkOutput("midreset_valid", data_valid_rx, 0);
        checkOutput("midreset_busy", busy_rx, 0);
        s_data_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idleLine(10);
        expectEvent(1, 0, 0, 8'h81);
        applyStimulus(8'h81, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 0);
        idleLine(30);

        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
